// File: rtl/fifo_pkg.sv
// Shared memory-chain definitions: bus widths, posted-write FSM encoding and
// downstream strobe/ready protocol levels used by spm, split, combine and fifo.
package fifo_pkg;
  localparam int ADDR_WIDTH = 64;
  localparam int WORD_WIDTH = 64;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_W_ISSUE = 3'd1;
  localparam logic [2:0] ST_W_WAIT  = 3'd2;
  localparam logic [2:0] ST_R_DRAIN = 3'd3;
  localparam logic [2:0] ST_R_ISSUE = 3'd4;
  localparam logic [2:0] ST_R_WAIT  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    W_ISSUE = ST_W_ISSUE,
    W_WAIT  = ST_W_WAIT,
    R_DRAIN = ST_R_DRAIN,
    R_ISSUE = ST_R_ISSUE,
    R_WAIT  = ST_R_WAIT
  } state_t;

  // Downstream protocol levels: strobes are one-cycle pulses, ready high = idle.
  localparam logic STROBE_ON  = 1'b1;
  localparam logic STROBE_OFF = 1'b0;
  localparam logic MEM_IDLE   = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } entry_t;
endpackage

// File: rtl/fifo_queue.sv
// Circular store of posted writes with newest-match address lookup.
// Push/pop take effect at the edge; lookup and head are combinational.
module fifo_queue
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  entry_t                  push_entry,
  input  logic                    pop,
  output entry_t                  head_entry,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr,
  output logic                    hit,
  output logic [WORD_WIDTH-1:0]   hit_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          store [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   idx;

  always_ff @(posedge clk) begin
    if (push) store[tail] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_entry = store[head];
  assign full       = (count == CW'(DEPTH));

  // Walk from oldest to newest so the entry nearest tail-1 wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = tail - PW'(i + 1);
      if (count > CW'(i) && store[idx].addr == lookup_addr) begin
        hit      = 1'b1;
        hit_data = store[idx].data;
      end
    end
  end
endmodule

// File: rtl/fifo.sv
// Posted-write buffer: writes ack in 0 waits and drain in order; reads forward on hit,
// else drain the queue then read downstream (>=3 edges). ready low when full or read pending.
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [WORD_WIDTH-1:0]  din,
  output logic [WORD_WIDTH-1:0]  dout,
  input  logic                   re,
  input  logic                   we,
  output logic                   ready,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WORD_WIDTH-1:0]  mem_din,
  input  logic [WORD_WIDTH-1:0]  mem_dout,
  output logic                   mem_re,
  output logic                   mem_we,
  input  logic                   mem_ready
);
  state_t                 state, state_nx;
  logic                   rd_pend, rd_pend_nx;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   pop, issue_rd;
  logic                   wr_acc, rd_acc, hit_acc, miss_acc;
  logic                   hit, full;
  logic [WORD_WIDTH-1:0]  hit_data;
  logic [$clog2(DEPTH):0] count;
  entry_t                 head_entry;

  fifo_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (wr_acc),
    .push_entry  ('{addr: addr, data: din}),
    .pop         (pop),
    .head_entry  (head_entry),
    .count       (count),
    .full        (full),
    .lookup_addr (addr),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  // A miss taken while a write is in flight holds ready low until the read
  // completes, so dout is never overwritten by a second request.
  assign ready    = !(state inside {R_DRAIN, R_ISSUE, R_WAIT}) && !rd_pend && !full;
  assign wr_acc   = ready && we;
  assign rd_acc   = ready && re && !we;
  assign hit_acc  = rd_acc && hit;
  assign miss_acc = rd_acc && !hit;

  always_comb begin
    state_nx   = state;
    rd_pend_nx = rd_pend || miss_acc;
    pop        = 1'b0;
    issue_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && mem_ready == MEM_IDLE) begin
          pop      = 1'b1;
          state_nx = W_ISSUE;
        end else if (miss_acc) begin
          state_nx = R_DRAIN;
        end
      end
      W_ISSUE: state_nx = W_WAIT;
      W_WAIT: begin
        if (mem_ready == MEM_IDLE) state_nx = rd_pend_nx ? R_DRAIN : IDLE;
      end
      R_DRAIN: begin
        if (mem_ready == MEM_IDLE) begin
          if (count != '0) begin
            pop      = 1'b1;
            state_nx = W_ISSUE;
          end else begin
            issue_rd   = 1'b1;
            rd_pend_nx = 1'b0;
            state_nx   = R_ISSUE;
          end
        end
      end
      R_ISSUE: state_nx = R_WAIT;
      R_WAIT: begin
        if (mem_ready == MEM_IDLE) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_pend  <= 1'b0;
      rd_addr  <= '0;
      dout     <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_re   <= STROBE_OFF;
      mem_we   <= STROBE_OFF;
    end else begin
      state   <= state_nx;
      rd_pend <= rd_pend_nx;
      mem_we  <= pop ? STROBE_ON : STROBE_OFF;
      mem_re  <= issue_rd ? STROBE_ON : STROBE_OFF;
      if (miss_acc) rd_addr <= addr;
      if (pop) begin
        mem_addr <= head_entry.addr;
        mem_din  <= head_entry.data;
      end else if (issue_rd) begin
        mem_addr <= rd_addr;
      end
      if (hit_acc) dout <= hit_data;
      else if (state == R_WAIT && mem_ready == MEM_IDLE) dout <= mem_dout;
    end
  end
endmodule

// File: tb/tb_fifo.sv
// Directed bench for the posted-write fifo with a small downstream ram model.
module tb_fifo;
  logic        clk = 1'b0;
  logic        rst, re, we, ready, mem_re, mem_we, mem_ready;
  logic [63:0] addr, din, dout, mem_addr, mem_din, mem_dout;

  typedef struct {
    logic        is_rd;
    logic [63:0] a;
    logic [63:0] d;
  } ev_t;

  ev_t         log_q[$];
  logic [63:0] ram     [512];
  logic        ram_vld [512] = '{default: 1'b0};
  logic        both_hi = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout), .re(re), .we(we),
    .ready(ready), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_re(mem_re), .mem_we(mem_we), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Downstream ram: unwritten words read back as A5A5_0000_0000_<addr>.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[8:0]]     <= mem_din;
      ram_vld[mem_addr[8:0]] <= 1'b1;
    end
    if (mem_re)
      mem_dout <= ram_vld[mem_addr[8:0]] ? ram[mem_addr[8:0]]
                                         : (64'ha5a5_0000_0000_0000 | mem_addr);
  end

  always @(negedge clk) begin
    if (mem_we) log_q.push_back('{is_rd: 1'b0, a: mem_addr, d: mem_din});
    if (mem_re) log_q.push_back('{is_rd: 1'b1, a: mem_addr, d: 64'd0});
    if (mem_we && mem_re) both_hi <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    re = 1'b0; we = 1'b0; addr = '0; din = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; idle_inputs();
    tick(); tick();
    rst = 1'b0;
    n_chk++; if (ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready got %h exp 1", ready); end
    n_chk++; if (mem_re !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_re got %h exp 0", mem_re); end
    n_chk++; if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_we got %h exp 0", mem_we); end
    n_chk++; if (dout !== 64'd0)   begin n_fail++; $display("FAIL reset_dout got %h exp 0", dout); end
    n_chk++; if (mem_addr !== 64'd0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    tick();
    n_chk++; if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL idle_mem_we got %h exp 0", mem_we); end
  endtask

  task automatic test_write_forward();
    log_q.delete();
    we = 1'b1; addr = 64'd1; din = 64'h0123456789abcdef;
    tick();
    we = 1'b0;
    n_chk++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL wr_ready got %h exp 1", ready); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_no_early_we got %h exp 0", mem_we); end
    re = 1'b1; addr = 64'd1;
    tick();
    re = 1'b0;
    n_chk++; if (dout !== 64'h0123456789abcdef) begin n_fail++; $display("FAIL fwd_dout got %h exp 0123456789abcdef", dout); end
    n_chk++; if (mem_we !== 1'b1)   begin n_fail++; $display("FAIL drain_we got %h exp 1", mem_we); end
    n_chk++; if (mem_addr !== 64'd1) begin n_fail++; $display("FAIL drain_addr got %h exp 1", mem_addr); end
    n_chk++; if (mem_din !== 64'h0123456789abcdef) begin n_fail++; $display("FAIL drain_din got %h exp 0123456789abcdef", mem_din); end
    n_chk++; if (ready !== 1'b1)    begin n_fail++; $display("FAIL fwd_ready got %h exp 1", ready); end
    tick();
    n_chk++; if (mem_we !== 1'b0)   begin n_fail++; $display("FAIL we_pulse_width got %h exp 0", mem_we); end
    repeat (4) tick();
    n_chk++; if (log_q.size() != 1) begin n_fail++; $display("FAIL fwd_access_count got %0d exp 1", log_q.size()); end
    else begin
      n_chk++; if (log_q[0].is_rd !== 1'b0) begin n_fail++; $display("FAIL fwd_no_mem_re got %h exp 0", log_q[0].is_rd); end
    end
  endtask

  task automatic test_full();
    log_q.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; addr = 64'(10 + i); din = 64'(100 + i);
      tick();
      if (i == 2) begin
        n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL full_ready3 got %h exp 1", ready); end
      end
    end
    we = 1'b0;
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready4 got %h exp 0", ready); end
    tick();
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_stalled got %h exp 0", ready); end
    mem_ready = 1'b1;
    tick();
    n_chk++; if (ready !== 1'b1)     begin n_fail++; $display("FAIL full_release got %h exp 1", ready); end
    n_chk++; if (mem_addr !== 64'd10) begin n_fail++; $display("FAIL full_first_pop got %0d exp 10", mem_addr); end
    repeat (20) tick();
    n_chk++; if (log_q.size() != 4) begin n_fail++; $display("FAIL full_drain_count got %0d exp 4", log_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (log_q[i].is_rd !== 1'b0 || log_q[i].a !== 64'(10 + i) || log_q[i].d !== 64'(100 + i)) begin
          n_fail++; $display("FAIL full_order[%0d] got a=%0d d=%0d rd=%h exp a=%0d d=%0d", i, log_q[i].a, log_q[i].d, log_q[i].is_rd, 10 + i, 100 + i);
        end
      end
    end
  endtask

  task automatic test_newest();
    mem_ready = 1'b0;
    we = 1'b1; addr = 64'd5; din = 64'd7; tick();
    we = 1'b1; addr = 64'd5; din = 64'd9; tick();
    we = 1'b0; re = 1'b1; addr = 64'd5; tick();
    re = 1'b0;
    n_chk++; if (dout !== 64'd9)  begin n_fail++; $display("FAIL newest_dout got %0d exp 9", dout); end
    n_chk++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL newest_ready got %h exp 1", ready); end
    mem_ready = 1'b1;
    repeat (12) tick();
    n_chk++; if (ram[5] !== 64'd9) begin n_fail++; $display("FAIL newest_ram got %0d exp 9", ram[5]); end
  endtask

  task automatic test_miss_empty();
    re = 1'b1; addr = 64'd300; tick();
    re = 1'b0;
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL miss_e0_ready got %h exp 0", ready); end
    tick();
    n_chk++; if (mem_re !== 1'b1 || mem_addr !== 64'd300) begin n_fail++; $display("FAIL miss_e1_issue got re=%h a=%0d exp re=1 a=300", mem_re, mem_addr); end
    tick();
    n_chk++; if (ready !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL miss_e2 got ready=%h re=%h exp 0 0", ready, mem_re); end
    tick();
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL miss_e3_ready got %h exp 1", ready); end
    n_chk++; if (dout !== 64'ha5a5_0000_0000_012c) begin n_fail++; $display("FAIL miss_dout got %h exp a5a500000000012c", dout); end
  endtask

  task automatic test_miss_after_writes();
    int waited;
    log_q.delete();
    we = 1'b1; addr = 64'd20; din = 64'haaaa; tick();
    we = 1'b1; addr = 64'd21; din = 64'hbbbb; tick();
    we = 1'b0; re = 1'b1; addr = 64'd257; tick();
    re = 1'b0;
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mw_ready_low got %h exp 0", ready); end
    waited = 0;
    while (ready !== 1'b1 && waited < 50) begin tick(); waited++; end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mw_timeout got ready=%h after %0d cycles exp 1", ready, waited); end
    n_chk++; if (dout !== 64'ha5a5_0000_0000_0101) begin n_fail++; $display("FAIL mw_dout got %h exp a5a5000000000101", dout); end
    n_chk++; if (log_q.size() != 3) begin n_fail++; $display("FAIL mw_access_count got %0d exp 3", log_q.size()); end
    else begin
      n_chk++; if (log_q[0].is_rd !== 1'b0 || log_q[0].a !== 64'd20) begin n_fail++; $display("FAIL mw_first got rd=%h a=%0d exp wr 20", log_q[0].is_rd, log_q[0].a); end
      n_chk++; if (log_q[1].is_rd !== 1'b0 || log_q[1].a !== 64'd21) begin n_fail++; $display("FAIL mw_second got rd=%h a=%0d exp wr 21", log_q[1].is_rd, log_q[1].a); end
      n_chk++; if (log_q[2].is_rd !== 1'b1 || log_q[2].a !== 64'd257) begin n_fail++; $display("FAIL mw_read got rd=%h a=%0d exp rd 257", log_q[2].is_rd, log_q[2].a); end
    end
  endtask

  task automatic test_reset_mid();
    log_q.delete();
    we = 1'b1; addr = 64'd30; din = 64'd1; tick();
    we = 1'b1; addr = 64'd31; din = 64'd2; tick();
    we = 1'b1; addr = 64'd32; din = 64'd3; mem_ready = 1'b0; tick();
    we = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; mem_ready = 1'b1;
    n_chk++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL rmid_ready got %h exp 1", ready); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_we got %h exp 0", mem_we); end
    n_chk++; if (dut.u_queue.count !== '0) begin n_fail++; $display("FAIL rmid_count got %0d exp 0", dut.u_queue.count); end
    repeat (10) tick();
    n_chk++; if (log_q.size() != 1) begin n_fail++; $display("FAIL rmid_writes got %0d exp 1", log_q.size()); end
    else begin
      n_chk++; if (log_q[0].a !== 64'd30) begin n_fail++; $display("FAIL rmid_addr got %0d exp 30", log_q[0].a); end
    end
  endtask

  task automatic test_strobes();
    n_chk++; if (both_hi !== 1'b0) begin n_fail++; $display("FAIL strobe_overlap got %h exp 0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_write_forward();
    test_full();
    test_newest();
    test_miss_empty();
    test_miss_after_writes();
    test_reset_mid();
    test_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo.md
# fifo

Posted-write buffer placed in the memory chain between a requester (`spm`, or a bench) and the next level (`split`, `combine`, `ram`). Writes are queued and acknowledged immediately, then drained downstream in order in the background. Reads forward from the queue on an address hit; on a miss they wait for the queue to empty before going downstream, so every read sees all earlier writes.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥ 2
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `addr`  in  64  upstream word address
- `din`  in  64  upstream write data
- `dout`  out  64  read data; valid while `ready`=1 after a read
- `re`  in  1  read request; sampled only when `ready`=1
- `we`  in  1  write request; sampled only when `ready`=1
- `ready`  out  1  1 = can accept a request and the last read result is valid
- `mem_addr`  out  64  downstream address (registered)
- `mem_din`  out  64  downstream write data (registered)
- `mem_dout`  in  64  downstream read data
- `mem_re`  out  1  downstream read strobe, one-cycle pulse
- `mem_we`  out  1  downstream write strobe, one-cycle pulse
- `mem_ready`  in  1  downstream idle / previous access complete

## Operation
- Queue: circular buffer of {addr, data}, with head, tail and count (width log2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Accept: a request is taken at an edge where `ready`=1 and `re`|`we`. If `re` and `we` are both high, it is treated as a write and `re` is ignored.
- Write: the entry is pushed at tail. No wait state. `ready` stays 1 unless count reaches DEPTH.
- Read hit: `addr` matches a queued entry. `dout` takes the data of the newest matching entry at the accept edge. `ready` stays 1 and no downstream access is made.
- Read miss: the block enters R_DRAIN and `ready`=0. The read address is latched.
- FSM states: IDLE, W_ISSUE, W_WAIT, R_DRAIN, R_ISSUE, R_WAIT.
  - IDLE / R_DRAIN → W_ISSUE when count>0 and `mem_ready`=1. At that edge: pop head, `mem_addr`/`mem_din` ← entry, `mem_we` ← 1.
  - R_DRAIN → R_ISSUE when count==0 and `mem_ready`=1. At that edge: `mem_addr` ← latched address, `mem_re` ← 1.
  - W_ISSUE → W_WAIT and R_ISSUE → R_WAIT unconditionally next edge; the strobe returns to 0.
  - W_WAIT → IDLE, or → R_DRAIN if a read is pending, at the first edge with `mem_ready`=1.
  - R_WAIT → IDLE at the first edge with `mem_ready`=1. At that edge `dout` ← `mem_dout`.
- `ready` = (state ∉ {R_DRAIN, R_ISSUE, R_WAIT}) && (count < DEPTH).
- A write in flight (already popped) is not a forwarding source. A read of that address misses, waits in R_DRAIN, and reads the written value from downstream.
- Simultaneous push and pop at one edge: count is unchanged. A push arriving while entry x is in flight is legal.
- Full: `ready`=0 until the next pop frees an entry.
- Reset: queue emptied and pending writes discarded; state IDLE; `ready`=1; `dout`, `mem_addr`, `mem_din` = 0; `mem_re`, `mem_we` = 0. A reset mid-transaction abandons it without waiting for `mem_ready`.

## Timing
- Write: `ready` is still 1 after the accept edge (when not full). First drain pulse at the earliest edge where state is IDLE and `mem_ready`=1, i.e. `mem_we` high one edge after the accept.
- Read hit: zero wait; `dout` is valid immediately after the accept edge.
- Read miss on an empty queue with always-ready downstream: accept E0 → R_ISSUE E1 → R_WAIT E2 → `ready`=1 after E3. Minimum 3 edges.
- `mem_re` and `mem_we` are each high for exactly one cycle per access and are never high together.
- Each queued write adds ≥ 2 edges plus the downstream latency to a pending read.

## Structure
- Shared package: ADDR_WIDTH=64, WORD_WIDTH=64, the state encoding localparams, and the downstream strobe/ready protocol constants reused by `spm`, `split`, `combine`.
- One natural sub-module, `fifo_queue`: storage, pointers, count, and the newest-match search (priority from tail−1 backward). The FSM lives in `fifo`.

## Test plan
- Reset, then idle: `ready`=1, `mem_re`=`mem_we`=0, `dout`=0.
- Write addr 1 data 0x0123456789abcdef → `ready` stays 1; one `mem_we` pulse with `mem_addr`=1 and that data. Then read addr 1 before drain completes → `dout`=0x0123456789abcdef with no `mem_re`.
- DEPTH=4, downstream `ram` stalled: 4 writes to addrs 10..13 → `ready`=0 after the 4th. It rises after the first pop; drain order is 10, 11, 12, 13.
- Write addr 5 = 7, then addr 5 = 9, then read 5 → `dout`=9 (newest entry wins).
- Two writes queued, then read addr 257 (miss) → `ready`=0; both `mem_we` pulses precede the `mem_re`. `ready` returns with `dout` = `ram` contents.
- Assert `rst` during W_WAIT with 2 entries queued → next cycle `ready`=1, count 0, no further `mem_we`.
